// File: rtl/fsm_pkt_gen.sv
// Transmit-side packet generator: wraps each accepted payload as {header, payload, seq}.
// Optional error injection on header LSB / sequence is compiled in with FSM_PKT_GEN_ERR_INJECT_EN.
module fsm_pkt_gen #(
  parameter int BUS_SIZE  = 16,
  parameter int WORD_SIZE = 4,
  parameter int WORD_NUM  = BUS_SIZE / WORD_SIZE,
  parameter int PAY_SIZE  = BUS_SIZE - 2 * WORD_SIZE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                in_valid,
  input  logic [PAY_SIZE-1:0] in_payload,
  output logic                in_ready,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [BUS_SIZE-1:0] bus_data_out,
  output logic [3:0]          state_control,
  output logic [15:0]         pkt_sent,
  input  logic                err_inj_hdr,
  input  logic                err_inj_seq
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_FIRST = 4'd1,
    S_REG   = 4'd2,
    S_DRAIN = 4'd3
  } state_e;

  localparam logic [WORD_SIZE-1:0] HDR     = '1;
  localparam logic [WORD_SIZE-1:0] SEQ_MAX = '1;
  localparam logic [WORD_SIZE-1:0] SEQ_ONE = WORD_SIZE'(1);

  if (WORD_NUM < 3 || WORD_NUM * WORD_SIZE != BUS_SIZE) begin : g_bad_cfg
    $error("fsm_pkt_gen: BUS_SIZE must hold at least 3 whole words");
  end

  // Sequence numbers run 1..SEQ_MAX; zero is reserved and never emitted.
  function automatic logic [WORD_SIZE-1:0] seq_next(input logic [WORD_SIZE-1:0] s);
    return (s == SEQ_MAX) ? SEQ_ONE : s + SEQ_ONE;
  endfunction

  state_e                state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic [BUS_SIZE-1:0]   bus_q, bus_d;
  logic [3:0]            state_control_q, state_control_d;
  logic [15:0]           pkt_sent_q, pkt_sent_d;
  logic [WORD_SIZE-1:0]  seq_q, seq_d;

  logic                  in_ready_c;
  logic                  accept;
  logic                  handshake;
  logic [WORD_SIZE-1:0]  hdr_word;
  logic [WORD_SIZE-1:0]  seq_sent;
  logic [WORD_SIZE-1:0]  seq_adv;

`ifndef FSM_PKT_GEN_ERR_INJECT_EN
  logic unused_err_inj;
  assign unused_err_inj = err_inj_hdr ^ err_inj_seq;
`endif

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    state_d         = state_q;
    out_valid_d     = out_valid_q;
    bus_d           = bus_q;
    pkt_sent_d      = pkt_sent_q;
    seq_d           = seq_q;

    handshake  = out_valid_q && out_ready;
    in_ready_c = reset && enable && (state_q == S_FIRST || state_q == S_REG)
                 && (!out_valid_q || out_ready);
    accept     = in_valid && in_ready_c;

`ifdef FSM_PKT_GEN_ERR_INJECT_EN
    hdr_word = HDR ^ WORD_SIZE'(err_inj_hdr);
    seq_sent = err_inj_seq ? seq_next(seq_q) : seq_q;
    seq_adv  = seq_next(seq_sent);
`else
    hdr_word = HDR;
    seq_sent = seq_q;
    seq_adv  = seq_next(seq_q);
`endif

    if (handshake && pkt_sent_q != 16'hFFFF) pkt_sent_d = pkt_sent_q + 16'd1;

    // A new accept in the handshake cycle keeps out_valid high for full throughput.
    if (accept) begin
      out_valid_d = 1'b1;
      bus_d       = {hdr_word, in_payload, seq_sent};
      seq_d       = seq_adv;
    end else if (handshake) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE:  if (enable) state_d = S_FIRST;
      S_FIRST: begin
        if (accept)       state_d = S_REG;
        else if (!enable) state_d = S_IDLE;
      end
      S_REG:   if (!enable) state_d = out_valid_q ? S_DRAIN : S_IDLE;
      // A word handed off in the same cycle enable dropped leaves nothing to drain.
      S_DRAIN: if (handshake || !out_valid_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) seq_d = SEQ_ONE;
    state_control_d = state_d;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      out_valid_q     <= 1'b0;
      bus_q           <= '0;
      state_control_q <= 4'd0;
      pkt_sent_q      <= 16'd0;
      seq_q           <= SEQ_ONE;
    end else begin
      state_q         <= state_d;
      out_valid_q     <= out_valid_d;
      bus_q           <= bus_d;
      state_control_q <= state_control_d;
      pkt_sent_q      <= pkt_sent_d;
      seq_q           <= seq_d;
    end
  end

  assign in_ready      = in_ready_c;
  assign out_valid     = out_valid_q;
  assign bus_data_out  = bus_q;
  assign state_control = state_control_q;
  assign pkt_sent      = pkt_sent_q;

endmodule

// File: tb/tb_fsm_pkt_gen.sv
// Self-checking bench for fsm_pkt_gen: directed scenarios plus randomized traffic against a reference model.
// Expected words under FSM_PKT_GEN_ERR_INJECT_EN follow the same macro as the design build.
module tb_fsm_pkt_gen;

`ifdef FSM_PKT_GEN_ERR_INJECT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_payload = 8'h00;
  logic        out_ready = 1'b0;
  logic        err_inj_hdr = 1'b0;
  logic        err_inj_seq = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] bus_data_out;
  logic [3:0]  state_control;
  logic [15:0] pkt_sent;

  int n_pass = 0;
  int n_total = 0;
  int exp_sent = 0;

  always #5 clk = ~clk;

  fsm_pkt_gen dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .in_valid     (in_valid),
    .in_payload   (in_payload),
    .in_ready     (in_ready),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .bus_data_out (bus_data_out),
    .state_control(state_control),
    .pkt_sent     (pkt_sent),
    .err_inj_hdr  (err_inj_hdr),
    .err_inj_seq  (err_inj_seq)
  );

  // Reference helpers: sequence numbers count 1..15 and wrap back to 1.
  function automatic int seq_after(input int s);
    return s % 15 + 1;
  endfunction

  function automatic logic [15:0] word(input logic [3:0] hdr, input logic [7:0] pay, input int seq);
    return {hdr, pay, 4'(seq)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Return to IDLE with nothing pending; bounded so a stuck FSM still reaches the summary.
  task automatic go_idle();
    int k;
    enable = 0; in_valid = 0; out_ready = 1; err_inj_hdr = 0; err_inj_seq = 0;
    k = 0;
    do begin
      step();
      k++;
    end while (state_control !== 4'd0 && k < 8);
    n_total++; if (state_control !== 4'd0) $display("FAIL go_idle: state %0d want 0", state_control); else n_pass++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      reset = 0;
      {enable, in_valid, out_ready, err_inj_hdr, err_inj_seq} = 5'($urandom);
      in_payload = 8'($urandom);
      step();
      {enable, in_valid, out_ready, err_inj_hdr, err_inj_seq} = 5'($urandom);
      in_payload = 8'($urandom);
      #1;
      n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
      n_total++; if (bus_data_out !== 16'h0) $display("FAIL rst_bus: got %h want 0000", bus_data_out); else n_pass++;
      n_total++; if (state_control !== 4'd0) $display("FAIL rst_state: got %0d want 0", state_control); else n_pass++;
      n_total++; if (pkt_sent !== 16'd0) $display("FAIL rst_pkt_sent: got %0d want 0", pkt_sent); else n_pass++;
      n_total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else n_pass++;
    end
    reset = 1; enable = 0; in_valid = 0; out_ready = 0; err_inj_hdr = 0; err_inj_seq = 0;
    exp_sent = 0;
    step();
    n_total++; if (state_control !== 4'd0) $display("FAIL post_rst_state: got %0d want 0", state_control); else n_pass++;
  endtask

  task automatic test_basic();
    enable = 1; out_ready = 1; in_valid = 1; in_payload = 8'hAB;
    #1;
    n_total++; if (in_ready !== 1'b0) $display("FAIL basic_idle_ready: got %b want 0", in_ready); else n_pass++;
    step();
    n_total++; if (state_control !== 4'd1) $display("FAIL basic_first: got %0d want 1", state_control); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL basic_first_ready: got %b want 1", in_ready); else n_pass++;
    step();
    n_total++; if ({out_valid, bus_data_out} !== {1'b1, 16'hFAB1}) $display("FAIL basic_w1: got %b/%h want 1/FAB1", out_valid, bus_data_out); else n_pass++;
    n_total++; if (state_control !== 4'd2) $display("FAIL basic_reg: got %0d want 2", state_control); else n_pass++;
    in_payload = 8'hCD;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL basic_b2b_ready: got %b want 1", in_ready); else n_pass++;
    step();
    n_total++; if ({out_valid, bus_data_out} !== {1'b1, 16'hFCD2}) $display("FAIL basic_w2: got %b/%h want 1/FCD2", out_valid, bus_data_out); else n_pass++;
    in_valid = 0;
    step();
    exp_sent += 2;
    n_total++; if (out_valid !== 1'b0) $display("FAIL basic_done_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (pkt_sent !== 16'(exp_sent)) $display("FAIL basic_pkt_sent: got %0d want %0d", pkt_sent, exp_sent); else n_pass++;
    go_idle();
  endtask

  task automatic test_stall();
    enable = 1; out_ready = 0; in_valid = 1; in_payload = 8'hAB;
    step();
    step();
    in_payload = 8'hCD;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++; if (in_ready !== 1'b0) $display("FAIL stall_ready[%0d]: got %b want 0", i, in_ready); else n_pass++;
      step();
      n_total++; if ({out_valid, bus_data_out} !== {1'b1, 16'hFAB1}) $display("FAIL stall_hold[%0d]: got %b/%h want 1/FAB1", i, out_valid, bus_data_out); else n_pass++;
    end
    out_ready = 1;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL stall_release_ready: got %b want 1", in_ready); else n_pass++;
    step();
    n_total++; if (bus_data_out !== 16'hFCD2) $display("FAIL stall_next_seq: got %h want FCD2", bus_data_out); else n_pass++;
    in_valid = 0;
    step();
    exp_sent += 2;
    n_total++; if (pkt_sent !== 16'(exp_sent)) $display("FAIL stall_pkt_sent: got %0d want %0d", pkt_sent, exp_sent); else n_pass++;
    go_idle();
  endtask

  task automatic test_wrap();
    int seq;
    int zero_seen;
    seq = 1;
    zero_seen = 0;
    enable = 1; out_ready = 1; in_valid = 1; in_payload = 8'h00;
    step();
    for (int i = 0; i < 16; i++) begin
      step();
      n_total++; if (bus_data_out !== word(4'hF, 8'h00, seq)) $display("FAIL wrap_word[%0d]: got %h want %h", i, bus_data_out, word(4'hF, 8'h00, seq)); else n_pass++;
      if (bus_data_out === 16'hF000) zero_seen++;
      seq = seq_after(seq);
    end
    n_total++; if (zero_seen !== 0) $display("FAIL wrap_no_zero_seq: got %0d words F000 want 0", zero_seen); else n_pass++;
    in_valid = 0;
    step();
    exp_sent += 16;
    n_total++; if (pkt_sent !== 16'(exp_sent)) $display("FAIL wrap_pkt_sent: got %0d want %0d", pkt_sent, exp_sent); else n_pass++;
    go_idle();
  endtask

  task automatic test_drain();
    enable = 1; out_ready = 0; in_valid = 1; in_payload = 8'h12;
    step();
    step();
    n_total++; if ({state_control, bus_data_out} !== {4'd2, 16'hF121}) $display("FAIL drain_pending: got %0d/%h want 2/F121", state_control, bus_data_out); else n_pass++;
    enable = 0;
    #1;
    n_total++; if (in_ready !== 1'b0) $display("FAIL drain_no_accept: got %b want 0", in_ready); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++; if ({state_control, out_valid, bus_data_out} !== {4'd3, 1'b1, 16'hF121}) $display("FAIL drain_hold[%0d]: got %0d/%b/%h want 3/1/F121", i, state_control, out_valid, bus_data_out); else n_pass++;
    end
    out_ready = 1;
    step();
    exp_sent += 1;
    n_total++; if ({state_control, out_valid} !== {4'd0, 1'b0}) $display("FAIL drain_exit: got %0d/%b want 0/0", state_control, out_valid); else n_pass++;
    enable = 1; in_payload = 8'h55;
    step();
    step();
    n_total++; if (bus_data_out !== 16'hF551) $display("FAIL drain_reenable: got %h want F551", bus_data_out); else n_pass++;
    in_valid = 0;
    step();
    exp_sent += 1;
    n_total++; if (pkt_sent !== 16'(exp_sent)) $display("FAIL drain_pkt_sent: got %0d want %0d", pkt_sent, exp_sent); else n_pass++;
    go_idle();
  endtask

  task automatic test_reset_mid();
    enable = 1; out_ready = 0; in_valid = 1; in_payload = 8'h77;
    step();
    step();
    n_total++; if (bus_data_out !== 16'hF771) $display("FAIL rmid_pending: got %h want F771", bus_data_out); else n_pass++;
    reset = 0;
    step();
    exp_sent = 0;
    n_total++; if ({out_valid, bus_data_out, state_control, pkt_sent, in_ready} !== 38'd0) $display("FAIL rmid_cleared: got %b/%h/%0d/%0d/%b want all 0", out_valid, bus_data_out, state_control, pkt_sent, in_ready); else n_pass++;
    reset = 1; enable = 0; in_valid = 0; out_ready = 1;
    step();
    n_total++; if ({out_valid, pkt_sent} !== 17'd0) $display("FAIL rmid_word_lost: got %b/%0d want 0/0", out_valid, pkt_sent); else n_pass++;
    enable = 1; in_valid = 1; in_payload = 8'h99;
    step();
    step();
    n_total++; if (bus_data_out !== 16'hF991) $display("FAIL rmid_restart: got %h want F991", bus_data_out); else n_pass++;
    in_valid = 0;
    step();
    exp_sent = 1;
    n_total++; if (pkt_sent !== 16'(exp_sent)) $display("FAIL rmid_pkt_sent: got %0d want %0d", pkt_sent, exp_sent); else n_pass++;
    go_idle();
  endtask

  task automatic test_err_inject();
    logic [15:0] exp;
    enable = 1; out_ready = 1; in_valid = 1; in_payload = 8'hAB; err_inj_hdr = 1;
    step();
    step();
    exp = ERR_EN ? 16'hEAB1 : 16'hFAB1;
    n_total++; if (bus_data_out !== exp) $display("FAIL err_hdr: got %h want %h", bus_data_out, exp); else n_pass++;
    err_inj_hdr = 0; in_valid = 0;
    step();
    exp_sent += 1;
    go_idle();
    enable = 1; in_valid = 1; err_inj_seq = 1;
    step();
    step();
    exp = ERR_EN ? 16'hFAB2 : 16'hFAB1;
    n_total++; if (bus_data_out !== exp) $display("FAIL err_seq: got %h want %h", bus_data_out, exp); else n_pass++;
    err_inj_seq = 0;
    step();
    exp = ERR_EN ? 16'hFAB3 : 16'hFAB2;
    n_total++; if (bus_data_out !== exp) $display("FAIL err_seq_next: got %h want %h", bus_data_out, exp); else n_pass++;
    in_valid = 0;
    step();
    exp_sent += 2;
    n_total++; if (pkt_sent !== 16'(exp_sent)) $display("FAIL err_pkt_sent: got %0d want %0d", pkt_sent, exp_sent); else n_pass++;
    go_idle();
  endtask

  // Random traffic within one burst; the model holds at most one pending word.
  task automatic test_random();
    bit          m_valid;
    logic [15:0] m_word;
    int          m_seq;
    int          sent;
    bit          exp_ready, acc, hs, inj_seq, inj_hdr;
    m_valid = 0; m_word = '0; m_seq = 1;
    enable = 1; in_valid = 0; out_ready = 0;
    step();
    for (int i = 0; i < 300; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      in_payload  = 8'($urandom);
      err_inj_hdr = ($urandom_range(0, 7) == 0);
      err_inj_seq = ($urandom_range(0, 7) == 0);
      #1;
      exp_ready = !m_valid || out_ready;
      n_total++; if (in_ready !== exp_ready) $display("FAIL rnd_ready[%0d]: got %b want %b", i, in_ready, exp_ready); else n_pass++;
      n_total++; if (out_valid !== m_valid) $display("FAIL rnd_valid[%0d]: got %b want %b", i, out_valid, m_valid); else n_pass++;
      if (m_valid) begin
        n_total++; if (bus_data_out !== m_word) $display("FAIL rnd_word[%0d]: got %h want %h", i, bus_data_out, m_word); else n_pass++;
      end
      acc = in_valid && exp_ready;
      hs  = m_valid && out_ready;
      inj_seq = ERR_EN && err_inj_seq;
      inj_hdr = ERR_EN && err_inj_hdr;
      if (hs) exp_sent++;
      if (acc) begin
        sent    = inj_seq ? seq_after(m_seq) : m_seq;
        m_seq   = seq_after(sent);
        m_word  = word(inj_hdr ? 4'hE : 4'hF, in_payload, sent);
        m_valid = 1;
      end else if (hs) begin
        m_valid = 0;
      end
      step();
    end
    in_valid = 0; out_ready = 1; err_inj_hdr = 0; err_inj_seq = 0;
    if (m_valid) exp_sent++;
    step();
    n_total++; if (pkt_sent !== 16'(exp_sent)) $display("FAIL rnd_pkt_sent: got %0d want %0d", pkt_sent, exp_sent); else n_pass++;
    go_idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_drain();
    test_reset_mid();
    test_err_inject();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
